ccsds_asm_randomizer: RTL and testbench

- Sits directly downstream of the LDPC encoder.
- Consumes the encoder's serial codeblock stream (1 bit per beat, tlast on the final codeblock bit).
- Applies the CCSDS pseudo-randomizer to the codeblock bits and prepends the 32-bit Attached Sync Marker (ASM).
- Emits a serial Channel Access Data Unit (CADU) stream with registered, fully back-pressurable AXI-Stream handshakes.

---
 rtl/ccsds_asm_randomizer.sv | 179 +++++++++++++++++
 tb/tb_ccsds_asm_randomizer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccsds_asm_randomizer.sv
// ---------------------------------------------------------------------------
// ccsds_asm_randomizer
//
// Turns the serial LDPC codeblock stream (one bit per beat, tlast on the
// final bit) into a serial CADU.  Each CADU is the 32-bit Attached Sync
// Marker sent MSB first, followed by the codeblock bits XORed with the CCSDS
// pseudo-random sequence h(x)=x^8+x^7+x^5+x^3+1.  The LFSR is reseeded to
// all ones at the start of every codeblock.
//
// The output side is a single registered AXI-Stream stage that can be fully
// back-pressured.  The input is accepted only while the block is emitting
// codeblock data and the output register can take a new beat.
//
// Parameters
//   ASM      sync marker word, sent MSB first
//   RAND_EN  1 = XOR data with the PN sequence, 0 = pass data unmodified
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   codeblock bit
//   s_axis_tvalid  input bit valid
//   s_axis_tlast   last bit of codeblock
//   s_axis_tready  block accepts input bit
//   m_axis_tdata   CADU bit
//   m_axis_tvalid  output bit valid
//   m_axis_tlast   last bit of CADU
//   m_axis_tuser   1 while the current beat is an ASM bit
//   m_axis_tready  downstream ready
// ---------------------------------------------------------------------------
module ccsds_asm_randomizer #(
    parameter logic [31:0] ASM     = 32'h1ACFFC1D,
    parameter bit          RAND_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_axis_tdata,
    input  logic s_axis_tvalid,
    input  logic s_axis_tlast,
    output logic s_axis_tready,
    output logic m_axis_tdata,
    output logic m_axis_tvalid,
    output logic m_axis_tlast,
    output logic m_axis_tuser,
    input  logic m_axis_tready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ASM  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [4:0]  r_asmCnt;
    logic [7:0]  r_lfsr;
    logic        r_mValid;
    logic        r_mData;
    logic        r_mLast;
    logic        r_mUser;

    logic        w_loadEn;
    logic        w_inHs;
    logic [4:0]  w_asmIdx;
    logic        w_startFrame;
    logic        w_beatAvail;
    logic        w_beatData;
    logic        w_beatLast;
    logic        w_beatUser;

    // The output register may take a new beat when it is empty or its
    // current beat is being taken this cycle.
    assign w_loadEn      = !r_mValid || m_axis_tready;
    assign s_axis_tready = (r_state == ST_DATA) && w_loadEn;
    assign w_inHs        = s_axis_tvalid && s_axis_tready;
    assign w_asmIdx      = 5'd31 - r_asmCnt;
    assign w_startFrame  = (r_state == ST_IDLE) && s_axis_tvalid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.  IDLE only watches tvalid; the pending input bit is
    // left in place and consumed later in DATA.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    w_nextState = ST_ASM;
                end
            end
            ST_ASM: begin
                if (w_loadEn && (r_asmCnt == 5'd31)) begin
                    w_nextState = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_inHs && s_axis_tlast) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Output decode: which beat, if any, is offered to the output register.
    always_comb begin
        w_beatAvail = 1'b0;
        w_beatData  = 1'b0;
        w_beatLast  = 1'b0;
        w_beatUser  = 1'b0;
        case (r_state)
            ST_ASM: begin
                w_beatAvail = 1'b1;
                w_beatData  = ASM[w_asmIdx];
                w_beatUser  = 1'b1;
            end
            ST_DATA: begin
                w_beatAvail = w_inHs;
                w_beatData  = s_axis_tdata ^ (RAND_EN ? r_lfsr[0] : 1'b0);
                w_beatLast  = s_axis_tlast;
            end
            default: begin
                w_beatAvail = 1'b0;
            end
        endcase
    end

    // ASM bit counter and PN generator.  Both restart at the IDLE->ASM step
    // so every codeblock begins with the full marker and the sequence FF 48..
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asmCnt <= 5'd0;
            r_lfsr   <= 8'hFF;
        end else begin
            if (w_startFrame) begin
                r_asmCnt <= 5'd0;
                r_lfsr   <= 8'hFF;
            end else begin
                if ((r_state == ST_ASM) && w_loadEn) begin
                    r_asmCnt <= r_asmCnt + 5'd1;
                end
                if (w_inHs) begin
                    r_lfsr <= {r_lfsr[0] ^ r_lfsr[3] ^ r_lfsr[5] ^ r_lfsr[7],
                               r_lfsr[7:1]};
                end
            end
        end
    end

    // Output register.  Holds everything while stalled; empties to all-zero
    // when it can load but nothing is offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mValid <= 1'b0;
            r_mData  <= 1'b0;
            r_mLast  <= 1'b0;
            r_mUser  <= 1'b0;
        end else if (w_loadEn) begin
            r_mValid <= w_beatAvail;
            r_mData  <= w_beatAvail && w_beatData;
            r_mLast  <= w_beatAvail && w_beatLast;
            r_mUser  <= w_beatAvail && w_beatUser;
        end
    end

    assign m_axis_tvalid = r_mValid;
    assign m_axis_tdata  = r_mData;
    assign m_axis_tlast  = r_mLast;
    assign m_axis_tuser  = r_mUser;

endmodule

// File: tb/tb_ccsds_asm_randomizer.sv
// ---------------------------------------------------------------------------
// tb_ccsds_asm_randomizer
//
// Two instances: the randomizing block and a RAND_EN=0 bypass copy.  The
// driver pushes each expected CADU beat ({tuser, tlast, tdata}) into a queue
// as it issues the corresponding stimulus; independent monitors pop and
// compare on every output handshake and watch that stalled outputs hold.
// ---------------------------------------------------------------------------
module tb_ccsds_asm_randomizer;

    logic clk;
    logic rst_n;

    logic sData, sValid, sLast, sReady;
    logic mData, mValid, mLast, mUser, mReady;

    logic sDataBy, sValidBy, sLastBy, sReadyBy;
    logic mDataBy, mValidBy, mLastBy, mUserBy;

    int checks;
    int errors;
    int beatIdx;
    int beatIdxBy;
    bit bpMode;

    logic [2:0] q[$];
    logic [2:0] qBy[$];
    bit         pn[255];
    logic [31:0] asmWord;
    logic [63:0] pnHead;

    logic       prevStall;
    logic [3:0] prevVec;

    ccsds_asm_randomizer #(.ASM(32'h1ACFFC1D), .RAND_EN(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (sData),
        .s_axis_tvalid (sValid),
        .s_axis_tlast  (sLast),
        .s_axis_tready (sReady),
        .m_axis_tdata  (mData),
        .m_axis_tvalid (mValid),
        .m_axis_tlast  (mLast),
        .m_axis_tuser  (mUser),
        .m_axis_tready (mReady)
    );

    ccsds_asm_randomizer #(.ASM(32'h1ACFFC1D), .RAND_EN(1'b0)) dutBy (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (sDataBy),
        .s_axis_tvalid (sValidBy),
        .s_axis_tlast  (sLastBy),
        .s_axis_tready (sReadyBy),
        .m_axis_tdata  (mDataBy),
        .m_axis_tvalid (mValidBy),
        .m_axis_tlast  (mLastBy),
        .m_axis_tuser  (mUserBy),
        .m_axis_tready (1'b1)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: 30% duty in back-pressure mode, otherwise always 1.
    initial begin
        mReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mReady = bpMode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Scoreboard monitor for the randomizing instance.
    always @(negedge clk) begin
        logic [2:0] exp;
        if (!rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stallHold", {4'b0, mValid, mUser, mLast, mData}, {4'b0, prevVec});
            end
            if (mValid && mReady) begin
                if (q.size() == 0) begin
                    reportTimeout("spuriousBeat");
                end else begin
                    exp = q.pop_front();
                    checkOutput($sformatf("beat%0d", beatIdx), {5'b0, mUser, mLast, mData}, {5'b0, exp});
                end
                beatIdx++;
            end
            prevStall = mValid && !mReady;
            prevVec   = {mValid, mUser, mLast, mData};
        end
    end

    // Scoreboard monitor for the bypass instance.
    always @(negedge clk) begin
        logic [2:0] exp;
        if (rst_n && mValidBy) begin
            if (qBy.size() == 0) begin
                reportTimeout("spuriousBeatBypass");
            end else begin
                exp = qBy.pop_front();
                checkOutput($sformatf("bypassBeat%0d", beatIdxBy), {5'b0, mUserBy, mLastBy, mDataBy}, {5'b0, exp});
            end
            beatIdxBy++;
        end
    end

    // Sends one codeblock.  kind: 0 = zeros, 1 = ones, 2 = random bits.
    // Stops early (without tlast) after abortAt accepted bits when abortAt>=0.
    task automatic applyStimulus(input int len, input int kind, input bit bubbles,
                                 input int abortAt, input bit checkLat, input bit toBypass);
        int  n = 0;
        int  pnIdx = 0;
        int  waitCnt = 0;
        int  cycles = 0;
        bit  curBit;
        bit  hs;
        for (int i = 0; i < 32; i++) begin
            if (toBypass) qBy.push_back({1'b1, 1'b0, asmWord[31-i]});
            else          q.push_back({1'b1, 1'b0, asmWord[31-i]});
        end
        curBit = (kind == 0) ? 1'b0 : (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        if (checkLat) begin
            sValid = 1'b1;
            sData  = curBit;
            sLast  = (len == 1);
            do begin
                @(negedge clk);
                cycles++;
            end while (!mValid && cycles < 10);
            checkOutput("asmLatency", 8'(cycles - 1), 8'd2);
            @(posedge clk);
            #1;
        end
        while (n < len) begin
            if (abortAt >= 0 && n == abortAt) break;
            if (toBypass) begin
                sValidBy = !(bubbles && $urandom_range(0, 3) == 0);
                sDataBy  = curBit;
                sLastBy  = (n == len - 1);
            end else begin
                sValid = !(bubbles && $urandom_range(0, 3) == 0);
                sData  = curBit;
                sLast  = (n == len - 1);
            end
            @(negedge clk);
            hs = toBypass ? (sValidBy && sReadyBy) : (sValid && sReady);
            if (hs) begin
                if (toBypass) qBy.push_back({1'b0, n == len - 1, curBit});
                else          q.push_back({1'b0, n == len - 1, curBit ^ pn[pnIdx % 255]});
                pnIdx++;
                n++;
                waitCnt = 0;
                curBit = (kind == 0) ? 1'b0 : (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                waitCnt++;
                if (waitCnt > 2000) begin
                    reportTimeout("inputAccept");
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        if (toBypass) begin
            sValidBy = 1'b0;
            sLastBy  = 1'b0;
        end else begin
            sValid = 1'b0;
            sLast  = 1'b0;
        end
    endtask

    task automatic drainQueues();
        int cnt = 0;
        while ((q.size() > 0 || qBy.size() > 0) && cnt < 6000) begin
            @(negedge clk);
            cnt++;
        end
        if (q.size() > 0 || qBy.size() > 0) begin
            reportTimeout("drain");
            q.delete();
            qBy.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        beatIdx   = 0;
        beatIdxBy = 0;
        bpMode    = 1'b0;
        prevStall = 1'b0;
        prevVec   = 4'b0;
        asmWord   = 32'h1ACFFC1D;
        // First 8 PN bytes, hand-expanded: FF 48 0E C0 9A 0D 70 BC.
        pnHead    = 64'hFF480EC09A0D70BC;
        for (int i = 0; i < 64; i++) pn[i] = pnHead[63-i];
        // Remaining bits from the output recurrence b[n+8]=b[n]^b[n+3]^b[n+5]^b[n+7].
        for (int i = 64; i < 255; i++) pn[i] = pn[i-8] ^ pn[i-5] ^ pn[i-3] ^ pn[i-1];

        rst_n    = 1'b0;
        sData    = 1'b0; sValid   = 1'b0; sLast   = 1'b0;
        sDataBy  = 1'b0; sValidBy = 1'b0; sLastBy = 1'b0;

        // Reset state.
        @(negedge clk);
        checkOutput("resetOutputs", {3'b0, mValid, mData, mLast, mUser, sReady}, 8'h00);
        checkOutput("resetOutputsBypass", {3'b0, mValidBy, mDataBy, mLastBy, mUserBy, sReadyBy}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle: no spurious ASM, never ready.
        $display("[TB] idle check");
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checkOutput("idleQuiet", {6'b0, mValid, sReady}, 8'h00);
        end
        @(posedge clk);
        #1;

        $display("[TB] all-zero codeblock, randomized");
        applyStimulus(8160, 0, 1'b0, -1, 1'b1, 1'b0);
        drainQueues();
        checkOutput("cadu8192Beats", 8'(beatIdx == 8192), 8'd1);

        $display("[TB] random codeblock, bypass");
        applyStimulus(8160, 2, 1'b0, -1, 1'b0, 1'b1);
        drainQueues();
        checkOutput("bypass8192Beats", 8'(beatIdxBy == 8192), 8'd1);

        $display("[TB] back-pressure with input bubbles");
        bpMode = 1'b1;
        applyStimulus(2000, 2, 1'b1, -1, 1'b0, 1'b0);
        drainQueues();
        bpMode = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back all-ones codeblocks");
        applyStimulus(8176, 1, 1'b0, -1, 1'b0, 1'b0);
        applyStimulus(8176, 1, 1'b0, -1, 1'b0, 1'b0);
        drainQueues();

        $display("[TB] reset mid-frame");
        applyStimulus(8160, 2, 1'b0, 1000, 1'b0, 1'b0);
        rst_n  = 1'b0;
        sValid = 1'b0;
        @(negedge clk);
        checkOutput("midResetOutputs", {3'b0, mValid, mData, mLast, mUser, sReady}, 8'h00);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(300, 0, 1'b0, -1, 1'b1, 1'b0);
        drainQueues();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
